// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave timer controller: FSM state encoding,
// BCD digit type, 7-segment patterns and a keypad decode helper.
package mw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } mw_state_e;

    typedef logic [3:0] bcd_t;

    // Segment order is {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic bcd_t onehot_to_digit(input logic [9:0] kp);
        bcd_t d;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            if (kp[i]) d = 4'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Single BCD digit to active-high 7-segment pattern; codes above 9 show blank.
module bcd_to_7seg
    import mw_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] segs
);
    always_comb begin
        segs = SEG_BLANK;
        case (digit)
            4'd0: segs = SEG_0;
            4'd1: segs = SEG_1;
            4'd2: segs = SEG_2;
            4'd3: segs = SEG_3;
            4'd4: segs = SEG_4;
            4'd5: segs = SEG_5;
            4'd6: segs = SEG_6;
            4'd7: segs = SEG_7;
            4'd8: segs = SEG_8;
            4'd9: segs = SEG_9;
            default: segs = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/mw_timer_ctrl.sv
// Microwave oven controller: MM:SS BCD entry, per-second countdown with duty-cycled power,
// +30 s quick start, pause/resume and end-of-cook beep. States: IDLE | SET | COOK | PAUSE | DONE.
module mw_timer_ctrl
    import mw_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned POWER_LEVELS  = 10,
    parameter int unsigned BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       powern,
    input  logic       add30n,
    input  logic       door_closed,
    output logic       mag_on,
    output logic       done_beep,
    output logic [3:0] power_level,
    output logic [2:0] state,
    output logic [6:0] sec_ones_segs,
    output logic [6:0] sec_tens_segs,
    output logic [6:0] min_ones_segs,
    output logic [6:0] min_tens_segs
);
    localparam int unsigned PRESC_W = $clog2(TICKS_PER_SEC);
    localparam int unsigned BEEP_W  = $clog2(BEEP_SECS + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [BEEP_W-1:0]  BEEP_LAST  = BEEP_W'(BEEP_SECS - 1);
    localparam logic [3:0]         POWER_MAX  = 4'(POWER_LEVELS);
    localparam logic [3:0]         DUTY_LAST  = 4'(POWER_LEVELS - 1);

    mw_state_e          state_q, state_d;
    bcd_t               so_q, st_q, mo_q, mt_q;
    bcd_t               so_d, st_d, mo_d, mt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         duty_q, duty_d;
    logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_d;
    logic [3:0]         power_q, power_d;
    logic               mag_on_q, mag_on_d;
    logic               done_beep_q, done_beep_d;
    logic               startn_q, stopn_q, powern_q, add30n_q;
    logic [9:0]         keypad_q;

    logic start_ev, stop_ev, power_ev, add30_ev, key_ev;
    bcd_t key_digit;
    logic tick, time_zero, dec_zero;
    logic [PRESC_W-1:0] presc_inc;
    logic [3:0] duty_next, power_step;

    assign start_ev  = startn_q & ~startn;
    assign stop_ev   = stopn_q & ~stopn;
    assign power_ev  = powern_q & ~powern;
    assign add30_ev  = add30n_q & ~add30n;
    assign key_ev    = (keypad_q == 10'd0) && (keypad != 10'd0) &&
                       ((keypad & (keypad - 10'd1)) == 10'd0);
    assign key_digit = onehot_to_digit(keypad);

    assign tick       = (presc_q == PRESC_LAST);
    assign presc_inc  = tick ? '0 : presc_q + PRESC_W'(1);
    assign duty_next  = (duty_q == DUTY_LAST) ? 4'd0 : duty_q + 4'd1;
    assign power_step = (power_q == 4'd1) ? POWER_MAX : power_q - 4'd1;
    assign time_zero  = ({mt_q, mo_q, st_q, so_q} == 16'd0);

    bcd_t dec_so, dec_st, dec_mo, dec_mt;

    always_comb begin
        dec_so = so_q - 4'd1;
        dec_st = st_q;
        dec_mo = mo_q;
        dec_mt = mt_q;
        if (so_q == 4'd0) begin
            dec_so = 4'd9;
            if (st_q != 4'd0) begin
                dec_st = st_q - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (mo_q != 4'd0) begin
                    dec_mo = mo_q - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = mt_q - 4'd1;
                end
            end
        end
    end

    assign dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'd0);

    // +30 s works on the already-decremented time when a tick lands in the same cycle
    bcd_t       base_so, base_st, base_mo, base_mt;
    bcd_t       add_so, add_st, add_mo, add_mt;
    logic [6:0] base_secs, base_mins, norm_secs;
    logic [7:0] sum_secs, sum_mins;

    always_comb begin
        base_so   = tick ? dec_so : so_q;
        base_st   = tick ? dec_st : st_q;
        base_mo   = tick ? dec_mo : mo_q;
        base_mt   = tick ? dec_mt : mt_q;
        base_secs = 7'(base_st) * 7'd10 + 7'(base_so);
        base_mins = 7'(base_mt) * 7'd10 + 7'(base_mo);
        sum_secs  = {1'b0, base_secs} + 8'd30;
        norm_secs = sum_secs[6:0];
        sum_mins  = {1'b0, base_mins};
        if (sum_secs >= 8'd120) begin
            norm_secs = 7'(sum_secs - 8'd120);
            sum_mins  = {1'b0, base_mins} + 8'd2;
        end else if (sum_secs >= 8'd60) begin
            norm_secs = 7'(sum_secs - 8'd60);
            sum_mins  = {1'b0, base_mins} + 8'd1;
        end
        add_mt = 4'(sum_mins / 8'd10);
        add_mo = 4'(sum_mins % 8'd10);
        add_st = 4'(norm_secs / 7'd10);
        add_so = 4'(norm_secs % 7'd10);
        if (sum_mins > 8'd99) begin
            add_mt = 4'd9;
            add_mo = 4'd9;
            add_st = 4'd5;
            add_so = 4'd9;
        end
    end

    always_comb begin
        state_d    = state_q;
        so_d       = so_q;
        st_d       = st_q;
        mo_d       = mo_q;
        mt_d       = mt_q;
        presc_d    = presc_q;
        duty_d     = duty_q;
        beep_cnt_d = beep_cnt_q;
        power_d    = power_q;

        case (state_q)
            ST_IDLE: begin
                if (add30_ev && door_closed) begin
                    {mt_d, mo_d, st_d, so_d} = {4'd0, 4'd0, 4'd3, 4'd0};
                    presc_d = '0;
                    duty_d  = 4'd0;
                    state_d = ST_COOK;
                end else if (power_ev) begin
                    power_d = power_step;
                end else if (key_ev) begin
                    {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_digit};
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                if (stop_ev) begin
                    {mt_d, mo_d, st_d, so_d} = 16'd0;
                    state_d = ST_IDLE;
                end else if (start_ev && door_closed && !time_zero) begin
                    presc_d = '0;
                    duty_d  = 4'd0;
                    state_d = ST_COOK;
                end else if (power_ev) begin
                    power_d = power_step;
                end else if (key_ev) begin
                    {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_digit};
                end
            end
            ST_COOK: begin
                if (!door_closed || stop_ev) begin
                    state_d = ST_PAUSE;
                end else begin
                    presc_d = presc_inc;
                    if (tick) begin
                        {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
                        duty_d = duty_next;
                    end
                    if (add30_ev) begin
                        {mt_d, mo_d, st_d, so_d} = {add_mt, add_mo, add_st, add_so};
                    end else if (tick && dec_zero) begin
                        beep_cnt_d = BEEP_LAST;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_ev) begin
                    {mt_d, mo_d, st_d, so_d} = 16'd0;
                    state_d = ST_IDLE;
                end else if (start_ev && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (!door_closed || stop_ev) begin
                    state_d = ST_IDLE;
                end else begin
                    presc_d = presc_inc;
                    if (tick) begin
                        if (beep_cnt_q == '0) state_d = ST_IDLE;
                        else beep_cnt_d = beep_cnt_q - BEEP_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mag_on_d    = (state_d == ST_COOK) && door_closed && (duty_d < power_d);
        done_beep_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            so_q        <= 4'd0;
            st_q        <= 4'd0;
            mo_q        <= 4'd0;
            mt_q        <= 4'd0;
            presc_q     <= '0;
            duty_q      <= 4'd0;
            beep_cnt_q  <= '0;
            power_q     <= POWER_MAX;
            mag_on_q    <= 1'b0;
            done_beep_q <= 1'b0;
            startn_q    <= 1'b1;
            stopn_q     <= 1'b1;
            powern_q    <= 1'b1;
            add30n_q    <= 1'b1;
            keypad_q    <= 10'd0;
        end else begin
            state_q     <= state_d;
            so_q        <= so_d;
            st_q        <= st_d;
            mo_q        <= mo_d;
            mt_q        <= mt_d;
            presc_q     <= presc_d;
            duty_q      <= duty_d;
            beep_cnt_q  <= beep_cnt_d;
            power_q     <= power_d;
            mag_on_q    <= mag_on_d;
            done_beep_q <= done_beep_d;
            startn_q    <= startn;
            stopn_q     <= stopn;
            powern_q    <= powern;
            add30n_q    <= add30n;
            keypad_q    <= keypad;
        end
    end

    assign mag_on      = mag_on_q;
    assign done_beep   = done_beep_q;
    assign power_level = power_q;
    assign state       = state_q;

    bcd_to_7seg u_seg_so (.digit(so_q), .segs(sec_ones_segs));
    bcd_to_7seg u_seg_st (.digit(st_q), .segs(sec_tens_segs));
    bcd_to_7seg u_seg_mo (.digit(mo_q), .segs(min_ones_segs));
    bcd_to_7seg u_seg_mt (.digit(mt_q), .segs(min_tens_segs));

endmodule

// File: tb/tb_mw_timer_ctrl.sv
// Bench for mw_timer_ctrl: directed oven scenarios plus random front-panel activity,
// every cycle compared against a seconds-level behavioural model of the oven.
module tb_mw_timer_ctrl;
    localparam int TPS = 4;
    localparam int PL  = 4;
    localparam int BS  = 2;

    localparam int M_IDLE = 0, M_SET = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

    logic       clk = 1'b0;
    logic       clear;
    logic [9:0] keypad;
    logic       startn, stopn, powern, add30n, door_closed;
    logic       mag_on, done_beep;
    logic [3:0] power_level;
    logic [2:0] state;
    logic [6:0] sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs;

    always #5 clk = ~clk;

    mw_timer_ctrl #(.TICKS_PER_SEC(TPS), .POWER_LEVELS(PL), .BEEP_SECS(BS)) dut (
        .clk(clk), .clear(clear), .keypad(keypad), .startn(startn), .stopn(stopn),
        .powern(powern), .add30n(add30n), .door_closed(door_closed),
        .mag_on(mag_on), .done_beep(done_beep), .power_level(power_level), .state(state),
        .sec_ones_segs(sec_ones_segs), .sec_tens_segs(sec_tens_segs),
        .min_ones_segs(min_ones_segs), .min_tens_segs(min_tens_segs)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int mag_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [27:0] disp(input int mm, input int ss);
        return {seg7(mm / 10), seg7(mm % 10), seg7(ss / 10), seg7(ss % 10)};
    endfunction

    // Reference model: time kept as whole minutes and seconds
    int m_st, m_min, m_sec, m_presc, m_duty, m_beep_secs, m_pow;
    bit m_mag, m_bp;
    bit p_start, p_stop, p_pow, p_a30;
    logic [9:0] p_kp;

    task automatic model_add30();
        int total;
        total = m_min * 60 + m_sec + 30;
        if (total > 99 * 60 + 59) begin
            m_min = 99;
            m_sec = 59;
        end else begin
            m_min = total / 60;
            m_sec = total % 60;
        end
    endtask

    task automatic model_key(input int kd);
        int old_sec;
        old_sec = m_sec;
        m_sec = (m_sec % 10) * 10 + kd;
        m_min = (m_min % 10) * 10 + old_sec / 10;
    endtask

    task automatic model_step();
        bit e_start, e_stop, e_pow, e_a30, e_key, sec_tick;
        int kd;
        e_start = p_start && !startn;
        e_stop  = p_stop && !stopn;
        e_pow   = p_pow && !powern;
        e_a30   = p_a30 && !add30n;
        e_key   = (p_kp == 10'd0) && ($countones(keypad) == 1);
        kd = 0;
        for (int i = 0; i < 10; i++) if (keypad[i]) kd = i;
        p_start = startn; p_stop = stopn; p_pow = powern; p_a30 = add30n; p_kp = keypad;
        if (clear) begin
            m_st = M_IDLE; m_min = 0; m_sec = 0; m_presc = 0; m_duty = 0; m_pow = PL;
            m_beep_secs = 0;
            p_start = 1; p_stop = 1; p_pow = 1; p_a30 = 1; p_kp = 10'd0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (e_a30 && door_closed) begin
                        m_min = 0; m_sec = 30; m_presc = 0; m_duty = 0; m_st = M_COOK;
                    end else if (e_pow) m_pow = (m_pow == 1) ? PL : m_pow - 1;
                    else if (e_key) begin
                        model_key(kd);
                        m_st = M_SET;
                    end
                end
                M_SET: begin
                    if (e_stop) begin
                        m_min = 0; m_sec = 0; m_st = M_IDLE;
                    end else if (e_start && door_closed && (m_min != 0 || m_sec != 0)) begin
                        m_presc = 0; m_duty = 0; m_st = M_COOK;
                    end else if (e_pow) m_pow = (m_pow == 1) ? PL : m_pow - 1;
                    else if (e_key) model_key(kd);
                end
                M_COOK: begin
                    if (!door_closed || e_stop) m_st = M_PAUSE;
                    else begin
                        sec_tick = (m_presc == TPS - 1);
                        m_presc = sec_tick ? 0 : m_presc + 1;
                        if (sec_tick) begin
                            if (m_sec > 0) m_sec--;
                            else begin
                                m_sec = 59;
                                m_min--;
                            end
                            m_duty = (m_duty + 1) % PL;
                        end
                        if (e_a30) model_add30();
                        else if (sec_tick && m_min == 0 && m_sec == 0) begin
                            m_beep_secs = 0;
                            m_st = M_DONE;
                        end
                    end
                end
                M_PAUSE: begin
                    if (e_stop) begin
                        m_min = 0; m_sec = 0; m_st = M_IDLE;
                    end else if (e_start && door_closed) m_st = M_COOK;
                end
                default: begin
                    if (!door_closed || e_stop) m_st = M_IDLE;
                    else if (m_presc == TPS - 1) begin
                        m_presc = 0;
                        m_beep_secs++;
                        if (m_beep_secs == BS) m_st = M_IDLE;
                    end else m_presc++;
                end
            endcase
        end
        m_mag = (m_st == M_COOK) && door_closed && (m_duty < m_pow) && !clear;
        m_bp  = (m_st == M_DONE);
    endtask

    task automatic tick1();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(state), 32'(m_st));
        chk("mag_on", 32'(mag_on), 32'(m_mag));
        chk("done_beep", 32'(done_beep), 32'(m_bp));
        chk("power_level", 32'(power_level), 32'(m_pow));
        chk("display", 32'({min_tens_segs, min_ones_segs, sec_tens_segs, sec_ones_segs}),
            32'(disp(m_min, m_sec)));
        if (mag_on && !door_closed) chk("mag_door", 32'(mag_on), 32'd0);
        if (mag_on) mag_cycles++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick1();
        clear = 1'b0;
    endtask

    task automatic key(input int d);
        keypad = 10'd1 << d;
        tick1();
        keypad = 10'd0;
        tick1();
    endtask

    task automatic press_start();
        startn = 1'b0; tick1(); startn = 1'b1; tick1();
    endtask
    task automatic press_stop();
        stopn = 1'b0; tick1(); stopn = 1'b1; tick1();
    endtask
    task automatic press_power();
        powern = 1'b0; tick1(); powern = 1'b1; tick1();
    endtask
    task automatic press_add30();
        add30n = 1'b0; tick1(); add30n = 1'b1; tick1();
    endtask

    function automatic logic [27:0] shown();
        return {min_tens_segs, min_ones_segs, sec_tens_segs, sec_ones_segs};
    endfunction

    initial begin
        int n;
        clear = 1'b1; keypad = 10'd0; startn = 1'b1; stopn = 1'b1;
        powern = 1'b1; add30n = 1'b1; door_closed = 1'b1;

        // Reset state and basic cook to completion
        do_clear();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_power", 32'(power_level), 32'(PL));
        chk("rst_disp", 32'(shown()), 32'(disp(0, 0)));
        key(1); key(2);
        chk("t1_disp", 32'(shown()), 32'(disp(0, 12)));
        chk("t1_state", 32'(state), 32'd1);
        press_start();
        chk("t1_cook", 32'(state), 32'd2);
        chk("t1_mag", 32'(mag_on), 32'd1);
        n = 0;
        while (state != 3'd4 && n < 200) begin tick1(); n++; end
        chk("t1_cook_len", 32'(n), 32'd47);
        n = 0;
        while (done_beep && n < 100) begin n++; tick1(); end
        chk("t1_beep_len", 32'(n), 32'd8);
        chk("t1_idle", 32'(state), 32'd0);

        // Borrow across the minute boundary
        do_clear();
        key(1); key(0); key(5);
        chk("t2_disp", 32'(shown()), 32'(disp(1, 5)));
        press_start();
        repeat (22) tick1();
        chk("t2_before", 32'(shown()), 32'(disp(1, 0)));
        tick1();
        chk("t2_borrow", 32'(shown()), 32'(disp(0, 59)));
        press_stop(); press_stop();

        // Door opens mid-second, pause holds the prescaler
        do_clear();
        key(1); key(0);
        press_start();
        tick1();
        door_closed = 1'b0;
        tick1();
        chk("t3_mag", 32'(mag_on), 32'd0);
        chk("t3_pause", 32'(state), 32'd3);
        chk("t3_held", 32'(shown()), 32'(disp(0, 10)));
        door_closed = 1'b1;
        tick1();
        press_start();
        chk("t3_resume", 32'(state), 32'd2);
        chk("t3_pre_tick", 32'(shown()), 32'(disp(0, 10)));
        tick1();
        chk("t3_tick", 32'(shown()), 32'(disp(0, 9)));
        press_stop(); press_stop();

        // Reduced power duty cycling
        do_clear();
        press_power(); press_power();
        chk("t4_power", 32'(power_level), 32'd2);
        key(8);
        mag_cycles = 0;
        press_start();
        n = 0;
        while (state != 3'd4 && n < 200) begin tick1(); n++; end
        chk("t4_mag_total", 32'(mag_cycles), 32'd16);
        n = 0;
        while (state != 3'd0 && n < 100) begin tick1(); n++; end

        // Quick start and saturation
        do_clear();
        press_add30();
        chk("t5_qs_state", 32'(state), 32'd2);
        chk("t5_qs_disp", 32'(shown()), 32'(disp(0, 30)));
        press_stop(); press_stop();
        key(9); key(9); key(4); key(5);
        press_start();
        press_add30();
        chk("t5_sat", 32'(shown()), 32'(disp(99, 59)));
        press_stop();
        chk("t5_pause", 32'(state), 32'd3);
        press_stop();
        chk("t5_idle", 32'(state), 32'd0);
        chk("t5_zero", 32'(shown()), 32'(disp(0, 0)));

        // Entry overflow, multi-hot keypad, start with door open
        do_clear();
        key(5); key(6); key(7); key(8); key(9);
        chk("t6_shift", 32'(shown()), 32'(disp(67, 89)));
        keypad = 10'b0000000110; tick1(); keypad = 10'd0; tick1();
        chk("t6_multihot", 32'(shown()), 32'(disp(67, 89)));
        door_closed = 1'b0;
        press_start();
        chk("t6_door_state", 32'(state), 32'd1);
        chk("t6_door_mag", 32'(mag_on), 32'd0);
        door_closed = 1'b1;

        // Random front-panel activity
        do_clear();
        for (int c = 0; c < 4000; c++) begin
            clear  = ($urandom_range(0, 399) == 0);
            startn = ($urandom_range(0, 9) != 0);
            stopn  = ($urandom_range(0, 39) != 0);
            powern = ($urandom_range(0, 19) != 0);
            add30n = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 59) == 0) door_closed = ~door_closed;
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 9) == 0) keypad = 10'($urandom) | 10'b11;
                else keypad = 10'd1 << $urandom_range(0, 9);
            end else keypad = 10'd0;
            tick1();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mw_timer_ctrl.md
Name: mw_timer_ctrl

Overview:
Parametrised next-generation microwave oven controller. Accepts one-hot keypad digits into a 4-digit MM:SS BCD entry register and counts down once per second while cooking. Adds selectable power level (magnetron duty cycling), a +30 s quick-start key, pause/resume, and an end-of-cook beep. Drives four 7-segment digits; sits at the top of the oven-control hierarchy, fed directly by debounced front-panel inputs.

Parameters:
TICKS_PER_SEC, 100, clk cycles per second of countdown (≥2)
POWER_LEVELS, 10, number of power settings; also the duty window length in seconds (2..15)
BEEP_SECS, 3, seconds done_beep stays asserted in DONE (≥1)

Ports:
clk  input  1  system clock
clear  input  1  synchronous active-high reset
keypad  input  10  one-hot digit keys, bit n = digit n
startn  input  1  start/resume, active-low
stopn  input  1  stop/pause/cancel, active-low
powern  input  1  power-level step key, active-low
add30n  input  1  +30 s key, active-low
door_closed  input  1  1 = door closed
mag_on  output  1  magnetron enable
done_beep  output  1  end-of-cook buzzer
power_level  output  4  current power setting, 1..POWER_LEVELS
state  output  3  FSM state encoding, for status LEDs and debug
sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs  output  7 each  segments {a,b,c,d,e,f,g}, active-high

Behaviour:
- Reset: clear is synchronous and active-high, and is sampled on the rising clk edge. On reset: state=IDLE; time=00:00; prescaler=0; duty counter=0; power_level=POWER_LEVELS; mag_on=0; done_beep=0; all segment outputs show "0" (7'b1111110). clear mid-cook drops mag_on on the same edge.
- Key events: startn, stopn, powern and add30n are registered. An event is a 1→0 edge (previous=1, current=0), producing one event per press.
- Keypad events: keypad becomes nonzero with exactly one bit set after an all-zero sample. Multi-hot values are ignored.
- Event priority within one cycle: clear > door open > stop > start > add30 > power > keypad.
- FSM states:
  - IDLE: display 00:00.
    - keypad: shift the digit into sec_ones; go to SET.
    - add30 with door closed: time=00:30, go to COOK.
    - power: decrement power_level; 1 wraps to POWER_LEVELS.
  - SET:
    - keypad: shift left, {mt,mo,st,so} ← {mo,st,so,key}; the old mt digit is discarded.
    - power: same as in IDLE.
    - start with door_closed and time≠00:00: go to COOK.
    - stop: time=00:00, go to IDLE.
    - Start while the door is open, or with zero time, is ignored.
  - COOK:
    - On entry from IDLE or SET: prescaler=0 and duty counter=0.
    - The prescaler counts 0..TICKS_PER_SEC-1. The cycle it equals TICKS_PER_SEC-1 is a tick, so the first decrement lands exactly TICKS_PER_SEC cycles after entry.
    - Tick: BCD decrement. so 0→9 with borrow from st; when seconds are 00 they become 59 with borrow from minutes. Entered seconds of 60–99 are counted as-is (01:75 → …00 → 00:59). Duty counter advances mod POWER_LEVELS.
    - When time reaches 00:00: go to DONE on that same edge.
    - stop, or door_closed=0: go to PAUSE.
    - add30: time += 30 s (BCD, seconds carry into minutes at ≥60 only after normalising), saturating at 99:59.
    - keypad and power are ignored.
  - PAUSE:
    - Prescaler and duty counter hold.
    - start with door_closed: resume COOK without reloading the counters.
    - stop: time=00:00, go to IDLE.
  - DONE:
    - done_beep=1; the prescaler counts BEEP_SECS seconds, then go to IDLE with done_beep=0.
    - stop, or door opening: go to IDLE immediately.
- mag_on = (state==COOK) && door_closed && (duty_cnt < power_level). It is registered from next-state, so it changes on the same edge as the state change. At the default power it is continuously on in COOK.
- mag_on must never be 1 while door_closed=0. The door-open check is combinational and takes priority; a door opening clears mag_on on the next edge at the latest.
- Segments are decoded combinationally from the BCD digits. Digits >9 (not reachable) display blank.

Decomposition:
- Package mw_pkg holds:
  - state enum: IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4
  - BCD digit typedef (4 bits)
  - segment constants for 0–9 and blank
- Sub-module bcd_to_7seg (BCD digit in, 7 segments out), instantiated four times.
- Countdown, entry, and FSM stay in mw_timer_ctrl.

Test Plan:
Benches run with TICKS_PER_SEC=4, POWER_LEVELS=4, BEEP_SECS=2.
1. clear, then keys 1, 2 → display 00:12, state=SET. Start → COOK, mag_on=1. After 12×4 cycles → 00:00, DONE, done_beep=1 for 8 cycles, then IDLE.
2. Entry 1, 0, 5 → 01:05. Start, then 6 ticks → 00:59 (borrow across the minute boundary).
3. COOK with 00:10. Door opens at prescaler=2 → mag_on=0 within 1 cycle, state=PAUSE, time held. Close the door and press start → resumes; the next tick comes after 1 cycle.
4. Power pressed twice in IDLE → power_level=2. Cook 00:08 → mag_on high for 2 s, low for 2 s, repeated; 4 s total on.
5. add30 in IDLE → 00:30 COOK. add30 at 99:45 → 99:59 (saturation). Stop → PAUSE; stop again → IDLE, 00:00.
6. Keys 5, 6, 7, 8, 9 → 67:89 (oldest digit dropped). Multi-hot keypad 10'b0000000110 → ignored. Start with the door open → stays SET, mag_on=0.
